// File: rtl/counter_load_sequencer.sv
`default_nettype none
// counter_load_sequencer: FIFO-buffered timed load commands, issued as one-cycle load pulses to the up-counter.
// Rev 1.0
module counter_load_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [W-1:0]             cmd_value,
  input  logic [3:0]               cmd_wait,
  input  logic                     flush,
  output logic                     load,
  output logic [W-1:0]             data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = W + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [3:0]      timer;
  logic [W-1:0]    data_hold;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty && !flush;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // Storage carries no reset: occupancy is tracked by level and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_value, cmd_wait};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // load/data are set on the edge entering FIRE so the strobe is a clean register output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      load      <= 1'b0;
      data      <= '0;
      timer     <= '0;
      data_hold <= '0;
    end else begin
      load <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              data_hold <= head[EW-1:4];
              timer     <= head[3:0];
              if (head[3:0] == 4'd0) begin
                state <= FIRE;
                load  <= 1'b1;
                data  <= head[EW-1:4];
              end else begin
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            timer <= timer - 4'd1;
            if (timer == 4'd1) begin
              state <= FIRE;
              load  <= 1'b1;
              data  <= data_hold;
            end
          end
          FIRE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
